// File: rtl/conv_enc_pkg.sv
// Shared constants, types and helpers for the rate-1/2 convolutional encoder frame controller.
// Polynomials are octal, right-aligned in 7 bits; the MSB taps the current input bit.
package conv_enc_pkg;

  localparam int K_MAX = 7;
  localparam int SR_W  = K_MAX - 1;

  localparam logic [2:0] CFG_K3 = 3'd0;
  localparam logic [2:0] CFG_K4 = 3'd1;
  localparam logic [2:0] CFG_K5 = 3'd2;
  localparam logic [2:0] CFG_K7 = 3'd3;

  localparam logic [6:0] G0_K3 = 7'o7;
  localparam logic [6:0] G1_K3 = 7'o5;
  localparam logic [6:0] G0_K4 = 7'o17;
  localparam logic [6:0] G1_K4 = 7'o15;
  localparam logic [6:0] G0_K5 = 7'o35;
  localparam logic [6:0] G1_K5 = 7'o23;
  localparam logic [6:0] G0_K7 = 7'o171;
  localparam logic [6:0] G1_K7 = 7'o133;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Reserved codes fall back to K=3.
  function automatic logic [2:0] k_len(input logic [2:0] k_sel);
    case (k_sel)
      CFG_K3:  k_len = 3'd3;
      CFG_K4:  k_len = 3'd4;
      CFG_K5:  k_len = 3'd5;
      CFG_K7:  k_len = 3'd7;
      default: k_len = 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] tail_len(input logic [2:0] k_sel);
    tail_len = k_len(k_sel) - 3'd1;
  endfunction

  function automatic logic [6:0] g0_of(input logic [2:0] k_sel);
    case (k_sel)
      CFG_K3:  g0_of = G0_K3;
      CFG_K4:  g0_of = G0_K4;
      CFG_K5:  g0_of = G0_K5;
      CFG_K7:  g0_of = G0_K7;
      default: g0_of = G0_K3;
    endcase
  endfunction

  function automatic logic [6:0] g1_of(input logic [2:0] k_sel);
    case (k_sel)
      CFG_K3:  g1_of = G1_K3;
      CFG_K4:  g1_of = G1_K4;
      CFG_K5:  g1_of = G1_K5;
      CFG_K7:  g1_of = G1_K7;
      default: g1_of = G1_K3;
    endcase
  endfunction

  function automatic logic [SR_W-1:0] state_mask(input logic [2:0] k_sel);
    case (k_sel)
      CFG_K3:  state_mask = 6'b000011;
      CFG_K4:  state_mask = 6'b000111;
      CFG_K5:  state_mask = 6'b001111;
      CFG_K7:  state_mask = 6'b111111;
      default: state_mask = 6'b000011;
    endcase
  endfunction

  // Reorders polynomial taps so bit j lines up with window bit j = {.., s2, s1, u}.
  function automatic logic [6:0] rev_poly(input logic [6:0] g, input logic [2:0] k);
    rev_poly = 7'd0;
    for (int j = 0; j < K_MAX; j++) begin
      if (j < int'(k)) rev_poly[j] = g[int'(k) - 1 - j];
      else             rev_poly[j] = 1'b0;
    end
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and parity generation for one K selection.
// The symbol output is combinational from the input bit and the registered state.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [2:0] k_sel_i,
  input  logic       u_i,
  output logic [1:0] sym_o
);

  logic [SR_W-1:0] st_q;
  logic [SR_W-1:0] st_d;
  logic [SR_W-1:0] mask_s;
  logic [6:0]      win_s;

  assign mask_s = state_mask(k_sel_i);
  assign win_s  = {st_q & mask_s, u_i};
  assign sym_o  = {^(win_s & rev_poly(g0_of(k_sel_i), k_len(k_sel_i))),
                   ^(win_s & rev_poly(g1_of(k_sel_i), k_len(k_sel_i)))};

  // Next state: clear at frame start, shift the current bit into s1 on each accepted symbol.
  always_comb begin
    st_d = st_q;
    if (clr_i) begin
      st_d = 6'd0;
    end else if (en_i) begin
      st_d = {st_q[SR_W-2:0], u_i} & mask_s;
    end else begin
      st_d = st_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= 6'd0;
    else     st_q <= st_d;
  end

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame controller: accepts a payload frame, serialises it LSB first through the encoder,
// appends K-1 zero tail bits and streams 2-bit symbols under valid/ready backpressure.
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int FRAME_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cfg_k,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAME_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_sym,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  // The index also counts tail bits (up to 5), so it needs at least 3 bits.
  localparam int IDX_W = ($clog2(FRAME_BITS) > 3) ? $clog2(FRAME_BITS) : 3;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   data_q, data_d;
  logic [2:0]              k_q, k_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             fc_q, fc_d;
  logic [FRAME_BITS-1:0]   data_sh_s;
  logic                    u_s;
  logic                    hs_s;
  logic                    accept_s;
  logic                    last_payload_s;
  logic                    last_tail_s;

  assign data_sh_s      = data_q >> idx_q;
  assign u_s            = (state_q == ENCODE) ? data_sh_s[0] : 1'b0;
  assign out_valid      = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign in_ready       = (state_q == IDLE);
  assign hs_s           = out_valid && out_ready;
  assign accept_s       = in_valid && in_ready;
  assign last_payload_s = (idx_q == IDX_W'(FRAME_BITS - 1));
  assign last_tail_s    = (idx_q == IDX_W'(tail_len(k_q) - 3'd1));
  assign out_last       = (state_q == FLUSH) && last_tail_s;
  assign frame_count    = fc_q;

  conv_enc_core u_core (
    .clk     (clk),
    .rst     (rst),
    .en_i    (hs_s),
    .clr_i   (accept_s),
    .k_sel_i (k_q),
    .u_i     (u_s),
    .sym_o   (out_sym)
  );

  // Frame FSM, payload/config latching, bit index and completed-frame counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ENCODE;
          data_d  = in_data;
          k_d     = cfg_k;
          idx_d   = IDX_W'(0);
        end else begin
          state_d = IDLE;
        end
      end
      ENCODE: begin
        if (hs_s && last_payload_s) begin
          state_d = FLUSH;
          idx_d   = IDX_W'(0);
        end else if (hs_s) begin
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          idx_d   = idx_q;
        end
      end
      FLUSH: begin
        if (hs_s && last_tail_s) begin
          state_d = IDLE;
          idx_d   = IDX_W'(0);
          fc_d    = fc_q + 16'd1;
        end else if (hs_s) begin
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          idx_d   = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_W'(0);
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= {FRAME_BITS{1'b0}};
      k_q     <= 3'd0;
      idx_q   <= IDX_W'(0);
      fc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Self-checking bench for conv_enc_frame_ctrl with FRAME_BITS=4 and a convolution-sum reference model.
module tb_conv_enc_frame_ctrl;

  localparam int FB = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    cfg_k;
  logic          in_valid;
  logic          in_ready;
  logic [FB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sym;
  logic          out_last;
  logic          busy;
  logic [15:0]   frame_count;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;

  logic [1:0] got_syms[$];
  logic       got_last[$];
  logic [1:0] exp_syms[$];
  logic [1:0] ref_k3[6];

  conv_enc_frame_ctrl #(.FRAME_BITS(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_k       (cfg_k),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sym     (out_sym),
    .out_last    (out_last),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int k_of(input logic [2:0] c);
    case (c)
      3'd0: return 3;
      3'd1: return 4;
      3'd2: return 5;
      3'd3: return 7;
      default: return 3;
    endcase
  endfunction

  function automatic int gpoly(input logic [2:0] c, input int which);
    case (c)
      3'd1: return (which == 0) ? 'o17 : 'o15;
      3'd2: return (which == 0) ? 'o35 : 'o23;
      3'd3: return (which == 0) ? 'o171 : 'o133;
      default: return (which == 0) ? 'o7 : 'o5;
    endcase
  endfunction

  // Symbol t = XOR over taps i of g[K-1-i] * b[t-i]; b is the payload followed by zeros.
  task automatic build_expected(input logic [FB-1:0] data, input logic [2:0] c);
    int k, n, b, p0, p1, g0, g1;
    k  = k_of(c);
    n  = FB + k - 1;
    g0 = gpoly(c, 0);
    g1 = gpoly(c, 1);
    exp_syms.delete();
    for (int t = 0; t < n; t++) begin
      p0 = 0;
      p1 = 0;
      for (int i = 0; i < k; i++) begin
        b = (t - i >= 0 && t - i < FB) ? int'(data[t - i]) : 0;
        p0 ^= ((g0 >> (k - 1 - i)) & 1) & b;
        p1 ^= ((g1 >> (k - 1 - i)) & 1) & b;
      end
      exp_syms.push_back({p0[0], p1[0]});
    end
  endtask

  task automatic drive_frame(input logic [FB-1:0] data, input logic [2:0] c, input logic [2:0] c_mid,
                             input bit rnd_ready, output int wait_cycles, output bit first_valid,
                             output bit stall_bad, output bit aborted);
    int guard;
    logic [1:0] held_sym;
    logic held_last;
    got_syms.delete();
    got_last.delete();
    wait_cycles = 0;
    stall_bad   = 1'b0;
    aborted     = 1'b0;
    first_valid = 1'b0;
    while (!in_ready && wait_cycles < 100) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    if (!in_ready) begin
      aborted = 1'b1;
      return;
    end
    in_valid = 1'b1;
    in_data  = data;
    cfg_k    = c;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_data     = FB'($urandom);
    cfg_k       = c_mid;
    first_valid = out_valid;
    guard       = 0;
    while (guard < 400) begin
      if (!out_valid) begin
        aborted = 1'b1;
        break;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      held_sym  = out_sym;
      held_last = out_last;
      @(posedge clk); #1;
      guard++;
      if (out_ready) begin
        got_syms.push_back(held_sym);
        got_last.push_back(held_last);
        if (held_last) break;
      end else if (out_valid !== 1'b1 || out_sym !== held_sym || out_last !== held_last) begin
        stall_bad = 1'b1;
      end
    end
    if (guard >= 400) aborted = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic compare_frame(input string name);
    checks++;
    if (got_syms.size() !== exp_syms.size()) begin
      errors++;
      $display("FAIL %s symbol count: got %0d expected %0d", name, got_syms.size(), exp_syms.size());
    end
    for (int i = 0; i < got_syms.size() && i < exp_syms.size(); i++) begin
      checks++;
      if (got_syms[i] !== exp_syms[i]) begin
        errors++;
        $display("FAIL %s sym[%0d]: got %b expected %b", name, i, got_syms[i], exp_syms[i]);
      end
      checks++;
      if (got_last[i] !== (i == exp_syms.size() - 1)) begin
        errors++;
        $display("FAIL %s last[%0d]: got %b expected %b", name, i, got_last[i], (i == exp_syms.size() - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({in_ready, out_valid, out_last, busy, out_sym, frame_count} !== {4'b1000, 2'b00, 16'd0}) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b vld=%b last=%b busy=%b sym=%b fc=%0d expected rdy=1 others 0",
               in_ready, out_valid, out_last, busy, out_sym, frame_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_k3_ref();
    int wc; bit fv, sb, ab;
    drive_frame(4'b1101, 3'd0, 3'd0, 1'b0, wc, fv, sb, ab);
    exp_fc++;
    exp_syms.delete();
    for (int i = 0; i < 6; i++) exp_syms.push_back(ref_k3[i]);
    checks++;
    if (ab || !fv) begin
      errors++;
      $display("FAIL k3_ref handshake: aborted=%b first_valid=%b expected 0/1", ab, fv);
    end
    compare_frame("k3_ref");
    checks++;
    if (frame_count !== 16'(exp_fc) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL k3_ref end: fc=%0d rdy=%b vld=%b expected fc=%0d rdy=1 vld=0", frame_count, in_ready, out_valid, exp_fc);
    end
  endtask

  task automatic test_backpressure();
    int wc; bit fv, sb, ab;
    drive_frame(4'b1101, 3'd0, 3'd0, 1'b1, wc, fv, sb, ab);
    exp_fc++;
    build_expected(4'b1101, 3'd0);
    checks++;
    if (ab || sb) begin
      errors++;
      $display("FAIL backpressure stability: aborted=%b stall_changed=%b expected 0/0", ab, sb);
    end
    compare_frame("backpressure");
  endtask

  task automatic test_k7_impulse();
    int wc; bit fv, sb, ab;
    drive_frame(4'b0001, 3'd3, 3'd3, 1'b0, wc, fv, sb, ab);
    exp_fc++;
    build_expected(4'b0001, 3'd3);
    checks++;
    if (got_syms.size() !== 10 || ab) begin
      errors++;
      $display("FAIL k7_impulse length: got %0d symbols expected 10", got_syms.size());
    end
    compare_frame("k7_impulse");
  endtask

  task automatic test_cfg_rules();
    int wc; bit fv, sb, ab;
    logic [FB-1:0] d;
    d = FB'($urandom);
    drive_frame(d, 3'd5, 3'd2, 1'b0, wc, fv, sb, ab);
    exp_fc++;
    build_expected(d, 3'd5);
    compare_frame("reserved_cfg");
    d = FB'($urandom);
    drive_frame(d, 3'd0, 3'd3, 1'b1, wc, fv, sb, ab);
    exp_fc++;
    build_expected(d, 3'd0);
    compare_frame("cfg_mid_frame");
    d = FB'($urandom);
    drive_frame(d, cfg_k, 3'd0, 1'b0, wc, fv, sb, ab);
    exp_fc++;
    build_expected(d, 3'd3);
    compare_frame("cfg_next_frame");
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL cfg frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_random();
    int wc; bit fv, sb, ab;
    logic [FB-1:0] d;
    logic [2:0] c;
    for (int f = 0; f < 8; f++) begin
      d = FB'($urandom);
      c = 3'($urandom_range(0, 7));
      drive_frame(d, c, 3'($urandom_range(0, 7)), 1'b1, wc, fv, sb, ab);
      exp_fc++;
      build_expected(d, c);
      checks++;
      if (sb || ab) begin
        errors++;
        $display("FAIL random[%0d] flow: stall_changed=%b aborted=%b expected 0/0", f, sb, ab);
      end
      compare_frame("random");
    end
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL random frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    int wc; bit fv, sb, ab;
    logic [FB-1:0] d;
    for (int f = 0; f < 3; f++) begin
      d = FB'($urandom);
      drive_frame(d, 3'd1, 3'd1, 1'b0, wc, fv, sb, ab);
      exp_fc++;
      build_expected(d, 3'd1);
      checks++;
      if (wc !== 0 || !fv || ab) begin
        errors++;
        $display("FAIL back_to_back[%0d] gap: waited=%0d first_valid=%b expected 0/1", f, wc, fv);
      end
      compare_frame("back_to_back");
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back[%0d] idle after last: rdy=%b busy=%b expected 1/0", f, in_ready, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    int wc; bit fv, sb, ab;
    logic [FB-1:0] d;
    in_valid  = 1'b1;
    in_data   = 4'b1011;
    cfg_k     = 3'd0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (FB) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pre: busy=%b vld=%b last=%b expected 1/1/0", busy, out_valid, out_last);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: vld=%b last=%b rdy=%b busy=%b fc=%0d expected 0/0/1/0/0",
               out_valid, out_last, in_ready, busy, frame_count);
    end
    exp_fc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    d = FB'($urandom);
    drive_frame(d, 3'd0, 3'd0, 1'b0, wc, fv, sb, ab);
    exp_fc++;
    build_expected(d, 3'd0);
    compare_frame("after_reset");
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL after_reset frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_wrap();
    int wc; bit fv, sb, ab;
    force dut.fc_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.fc_q;
    @(posedge clk); #1;
    checks++;
    if (frame_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap preload: got %h expected ffff", frame_count);
    end
    drive_frame(FB'($urandom), 3'd0, 3'd0, 1'b0, wc, fv, sb, ab);
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap: got %h expected 0000", frame_count);
    end
  endtask

  initial begin
    ref_k3    = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    rst       = 1'b1;
    cfg_k     = 3'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_k3_ref();
    test_backpressure();
    test_k7_impulse();
    test_cfg_rules();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
